// File: rtl/tensor_serializer.sv
// ============================================================================
// Module   : tensor_serializer
// Brief    : Snapshots a channel x frame tensor on a done tick and streams it
//            out one sample per transfer over valid/ready, channel-major.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tensor_serializer #(
  parameter  int NUM_CHANNELS       = 2,
  parameter  int FRAMES_PER_CHANNEL = 4,
  parameter  int DATA_WIDTH         = 16,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int FW = (FRAMES_PER_CHANNEL > 1) ? $clog2(FRAMES_PER_CHANNEL) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_done_tick,
  input  logic signed [DATA_WIDTH-1:0] i_data [0:NUM_CHANNELS-1][0:FRAMES_PER_CHANNEL-1],
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic [CW-1:0]                o_ch_idx,
  output logic [FW-1:0]                o_fr_idx,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_block_done_tick,
  output logic                         o_overrun_tick
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_last_ch = CW'(NUM_CHANNELS - 1);
  localparam logic [FW-1:0] c_last_fr = FW'(FRAMES_PER_CHANNEL - 1);
  localparam logic          c_single  = (NUM_CHANNELS == 1) && (FRAMES_PER_CHANNEL == 1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic signed [DATA_WIDTH-1:0]   r_buf [0:NUM_CHANNELS-1][0:FRAMES_PER_CHANNEL-1];
  logic [CW-1:0]                  r_ch;
  logic [CW-1:0]                  w_ch_nxt;
  logic [FW-1:0]                  r_fr;
  logic [FW-1:0]                  w_fr_nxt;
  logic signed [DATA_WIDTH-1:0]   r_data;
  logic signed [DATA_WIDTH-1:0]   w_data_nxt;
  logic                           r_last;
  logic                           w_last_nxt;
  logic                           r_done;
  logic                           w_done_nxt;
  logic                           r_over;
  logic                           w_over_nxt;
  logic                           w_capture;
  logic                           w_xfer;
  logic                           w_final;

  assign w_xfer  = (r_state == S_STREAM) && i_ready;
  assign w_final = (r_ch == c_last_ch) && (r_fr == c_last_fr);

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_fr_nxt    = r_fr;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_over_nxt  = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_done_tick) begin
          w_capture   = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_xfer && w_final) begin
          w_done_nxt = 1'b1;
          // A tick coinciding with the final transfer chains the next tensor.
          if (i_done_tick) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = 1'b0;
          end
        end else begin
          if (w_xfer) begin
            if (r_fr == c_last_fr) begin
              w_fr_nxt = '0;
              w_ch_nxt = r_ch + 1'b1;
            end else begin
              w_fr_nxt = r_fr + 1'b1;
            end
            w_data_nxt = r_buf[w_ch_nxt][w_fr_nxt];
            w_last_nxt = (w_ch_nxt == c_last_ch) && (w_fr_nxt == c_last_fr);
          end
          w_over_nxt = i_done_tick;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Capture presents sample (0,0) straight from the input array.
    if (w_capture) begin
      w_ch_nxt   = '0;
      w_fr_nxt   = '0;
      w_data_nxt = i_data[0][0];
      w_last_nxt = c_single;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_fr    <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_fr    <= w_fr_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_over  <= w_over_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf <= i_data;
    end
  end

  assign o_valid           = (r_state == S_STREAM);
  assign o_busy            = (r_state == S_STREAM);
  assign o_data            = r_data;
  assign o_ch_idx          = r_ch;
  assign o_fr_idx          = r_fr;
  assign o_last            = r_last;
  assign o_block_done_tick = r_done;
  assign o_overrun_tick    = r_over;

endmodule

`default_nettype wire

// File: tb/tb_tensor_serializer.sv
// ============================================================================
// Module   : tb_tensor_serializer
// Brief    : Randomized self-checking bench for tensor_serializer against a
//            queue-based transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tensor_serializer;

  localparam int N  = 2;
  localparam int F  = 4;
  localparam int DW = 16;

  typedef logic signed [DW-1:0] tens_t [0:N-1][0:F-1];
  typedef struct {
    logic signed [DW-1:0] d;
    int                   ch;
    int                   fr;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_done_tick;
  logic signed [DW-1:0] i_data [0:N-1][0:F-1];
  logic                 o_valid;
  logic                 i_ready;
  logic signed [DW-1:0] o_data;
  logic [0:0]           o_ch_idx;
  logic [1:0]           o_fr_idx;
  logic                 o_last;
  logic                 o_busy;
  logic                 o_block_done_tick;
  logic                 o_overrun_tick;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  bit   exp_done;
  bit   exp_over;

  tensor_serializer #(
    .NUM_CHANNELS      (N),
    .FRAMES_PER_CHANNEL(F),
    .DATA_WIDTH        (DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_done_tick      (i_done_tick),
    .i_data           (i_data),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_data           (o_data),
    .o_ch_idx         (o_ch_idx),
    .o_fr_idx         (o_fr_idx),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_block_done_tick(o_block_done_tick),
    .o_overrun_tick   (o_overrun_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_tensor(input tens_t d);
    for (int c = 0; c < N; c++)
      for (int f = 0; f < F; f++)
        q.push_back('{d: d[c][f], ch: c, fr: f});
  endtask

  // One clock: apply inputs, advance the model across the edge, check outputs.
  task automatic step(input bit rst_lo, input bit tick, input tens_t d, input bit rdy);
    bit   valid;
    ent_t e;
    rst_n       = !rst_lo;
    i_done_tick = tick;
    i_data      = d;
    i_ready     = rdy;
    @(posedge clk);
    exp_done = 1'b0;
    exp_over = 1'b0;
    if (rst_lo) begin
      q.delete();
    end else begin
      valid = (q.size() > 0);
      if (valid && rdy) begin
        e = q.pop_front();
        if (q.size() == 0) begin
          exp_done = 1'b1;
          if (tick) push_tensor(d);
        end else if (tick) begin
          exp_over = 1'b1;
        end
      end else if (tick) begin
        if (valid) exp_over = 1'b1;
        else       push_tensor(d);
      end
    end
    @(negedge clk);
    check("valid",    32'(o_valid),           32'(q.size() > 0));
    check("busy",     32'(o_busy),            32'(q.size() > 0));
    check("done",     32'(o_block_done_tick), 32'(exp_done));
    check("overrun",  32'(o_overrun_tick),    32'(exp_over));
    if (q.size() > 0) begin
      check("data",   32'(o_data),   32'(q[0].d));
      check("ch_idx", 32'(o_ch_idx), 32'(q[0].ch));
      check("fr_idx", 32'(o_fr_idx), 32'(q[0].fr));
      check("last",   32'(o_last),   32'(q.size() == 1));
    end
    if (rst_lo) begin
      check("rst_data", 32'(o_data),   32'd0);
      check("rst_ch",   32'(o_ch_idx), 32'd0);
      check("rst_fr",   32'(o_fr_idx), 32'd0);
      check("rst_last", 32'(o_last),   32'd0);
    end
  endtask

  task automatic drain(input int pattern, input int budget);
    int k;
    k = 0;
    while (q.size() > 0 && k < budget) begin
      step(1'b0, 1'b0, zero_t(), (pattern == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3)));
      k++;
    end
    if (q.size() > 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  function automatic tens_t zero_t();
    tens_t t;
    for (int c = 0; c < N; c++)
      for (int f = 0; f < F; f++)
        t[c][f] = '0;
    return t;
  endfunction

  function automatic tens_t rand_t();
    tens_t t;
    for (int c = 0; c < N; c++)
      for (int f = 0; f < F; f++)
        t[c][f] = DW'($urandom);
    return t;
  endfunction

  initial begin
    tens_t base, sgn, sevens, t2;
    base = '{'{16'sd363, 16'sd542, 16'sd542, 16'sd338},
             '{16'sd408, 16'sd609, 16'sd609, 16'sd380}};
    sgn  = '{'{-16'sd5, 16'sd1, -16'sd32768, 16'sd32767},
             '{16'sh8000, 16'shFFFB, 16'sd0, -16'sd1}};
    for (int c = 0; c < N; c++)
      for (int f = 0; f < F; f++)
        sevens[c][f] = 16'sd7;

    // Reset state
    step(1'b1, 1'b0, zero_t(), 1'b0);
    step(1'b0, 1'b0, zero_t(), 1'b1);

    // Basic stream, then backpressure
    step(1'b0, 1'b1, base, 1'b1);
    drain(0, 20);
    step(1'b0, 1'b0, zero_t(), 1'b1);
    step(1'b0, 1'b1, base, 1'b0);
    drain(1, 40);

    // Signed passthrough
    step(1'b0, 1'b1, sgn, 1'b1);
    drain(0, 20);

    // Overrun while (0,2) pending
    step(1'b0, 1'b1, base, 1'b1);
    step(1'b0, 1'b0, zero_t(), 1'b1);
    step(1'b0, 1'b0, zero_t(), 1'b1);
    step(1'b0, 1'b1, sevens, 1'b0);
    drain(0, 20);

    // Zero-bubble chaining on the final transfer
    step(1'b0, 1'b1, base, 1'b1);
    for (int k = 0; k < 20 && q.size() > 1; k++) step(1'b0, 1'b0, zero_t(), 1'b1);
    step(1'b0, 1'b1, sgn, 1'b1);
    check("chain_new_data", 32'(o_data), 32'(-32'sd5));
    drain(0, 20);

    // Reset mid-stream after 3 transfers, then restart
    step(1'b0, 1'b1, base, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, zero_t(), 1'b1);
    step(1'b1, 1'b0, zero_t(), 1'b1);
    step(1'b0, 1'b0, zero_t(), 1'b1);
    t2 = rand_t();
    step(1'b0, 1'b1, t2, 1'b1);
    drain(1, 40);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), rand_t(),
           1'($urandom_range(0, 1)));
    end
    drain(0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
